// File: rtl/even_counter_ctrl.sv
// Board-input front end for the even up/down counter: synchronizes and debounces the
// pushbuttons, turns presses into one-cycle commands and adds optional auto-run steps.
module even_counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_DIV        = 8,
  parameter int PRE_W           = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic       sw_dir,
  input  logic       sw_auto,
  input  logic [3:0] sw_data,
  output logic       load,
  output logic       count_en,
  output logic [1:0] c,
  output logic [3:0] data_in
);

  localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  // The sync chain reads 0 for two cycles after reset, so arming needs a longer quiet run.
  localparam int ARM_CYCLES = (DEBOUNCE_CYCLES > 3) ? DEBOUNCE_CYCLES : 3;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic [8:0] raw_vec;
  logic [8:0] sync1_reg;
  logic [8:0] sync2_reg;
  logic [2:0] press;
  logic [PRE_W-1:0] pre_reg;
  logic       tick;
  logic       auto_sync;
  logic       dir_sync;
  logic [3:0] data_sync;
  logic       load_next;
  logic       count_en_next;
  logic [1:0] c_next;
  logic [3:0] data_next;

  assign raw_vec   = {sw_data, sw_auto, sw_dir, btn_load, btn_down, btn_up};
  assign dir_sync  = sync2_reg[3];
  assign auto_sync = sync2_reg[4];
  assign data_sync = sync2_reg[8:5];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_vec;
      sync2_reg <= sync1_reg;
    end
  end

  // Bit 0 = up, 1 = down, 2 = load.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic [DB_W-1:0]  db_cnt_reg;
      logic [ARM_W-1:0] arm_cnt_reg;
      logic             db_reg;
      logic             db_prev_reg;
      logic             armed_reg;
      logic             lvl;

      assign lvl = sync2_reg[gi];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          db_cnt_reg  <= '0;
          arm_cnt_reg <= '0;
          db_reg      <= 1'b0;
          db_prev_reg <= 1'b0;
          armed_reg   <= 1'b0;
        end else begin
          db_prev_reg <= db_reg;
          if (lvl != db_reg) begin
            if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
              db_reg     <= lvl;
              db_cnt_reg <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end
          end else begin
            db_cnt_reg <= '0;
          end
          // A press is only honoured once the button has been seen released after reset.
          if (!lvl && !db_reg) begin
            if (arm_cnt_reg != ARM_W'(ARM_CYCLES))
              arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
          end else begin
            arm_cnt_reg <= '0;
          end
          if (arm_cnt_reg == ARM_W'(ARM_CYCLES))
            armed_reg <= 1'b1;
        end
      end

      assign press[gi] = db_reg & ~db_prev_reg & armed_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_reg <= '0;
    end else if (!auto_sync || pre_reg == PRE_W'(AUTO_DIV - 1)) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_reg + PRE_W'(1);
    end
  end

  assign tick = auto_sync && (pre_reg == PRE_W'(AUTO_DIV - 1));

  always_comb begin
    load_next     = 1'b0;
    count_en_next = 1'b0;
    c_next        = 2'b11;
    data_next     = data_in;
    if (press[2]) begin
      load_next = 1'b1;
      data_next = data_sync;
    end else if (press[0] ^ press[1]) begin
      count_en_next = 1'b1;
      c_next        = press[1] ? 2'b01 : 2'b00;
    end else if (!(press[0] | press[1]) && tick) begin
      count_en_next = 1'b1;
      c_next        = dir_sync ? 2'b01 : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load     <= 1'b0;
      count_en <= 1'b0;
      c        <= 2'b11;
      data_in  <= '0;
    end else begin
      load     <= load_next;
      count_en <= count_en_next;
      c        <= c_next;
      data_in  <= data_next;
    end
  end

endmodule

// File: tb/tb_even_counter_ctrl.sv
// Directed bench for even_counter_ctrl: table of button records plus hand-written
// auto-run and reset-mid-press sequences.
module tb_even_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_load, sw_dir, sw_auto;
  logic [3:0] sw_data;
  logic       load, count_en;
  logic [1:0] c;
  logic [3:0] data_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] held_data = 4'h0;

  always #5 clk = ~clk;

  even_counter_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_DIV(8), .PRE_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
    .sw_dir(sw_dir), .sw_auto(sw_auto), .sw_data(sw_data),
    .load(load), .count_en(count_en), .c(c), .data_in(data_in)
  );

  typedef struct {
    logic       up;
    logic       down;
    logic       ld;
    logic [3:0] data;
    int         cycles;
    int         pulse_at;   // cycle index after the first sampling edge, -1 = none
    logic       exp_load;
    logic       exp_ce;
    logic [1:0] exp_c;
    logic [3:0] exp_data;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {load, count_en, c, data_in};
  endfunction

  // Called at a falling edge; cycle k is sampled on the falling edge after rising edge k.
  task automatic apply(input vec_t v, input int idx);
    logic [7:0] exp;
    int pulses;
    pulses   = 0;
    btn_up   = v.up;
    btn_down = v.down;
    btn_load = v.ld;
    sw_data  = v.data;
    for (int k = 0; k < v.cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == v.pulse_at)
        exp = {v.exp_load, v.exp_ce, v.exp_c, v.exp_data};
      else if (v.pulse_at >= 0 && k > v.pulse_at)
        exp = {1'b0, 1'b0, 2'b11, v.exp_data};
      else
        exp = {1'b0, 1'b0, 2'b11, held_data};
      if (load | count_en) pulses++;
      check($sformatf("rec%0d_cyc%0d", idx, k), 32'(outs()), 32'(exp));
    end
    if (v.pulse_at >= 0) held_data = v.exp_data;
    $display("rec %0d: up=%b down=%b ld=%b data=%h cycles=%0d pulses_seen=%0d data_in=%h",
             idx, v.up, v.down, v.ld, v.data, v.cycles, pulses, data_in);
  endtask

  initial begin
    //            up    down  ld    data   cyc pulse load  ce    c      data
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 12, -1, 1'b0, 1'b0, 2'b11, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 20,  6, 1'b0, 1'b1, 2'b00, 4'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 12, -1, 1'b0, 1'b0, 2'b11, 4'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h0,  2, -1, 1'b0, 1'b0, 2'b11, 4'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h0,  2, -1, 1'b0, 1'b0, 2'b11, 4'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'h0,  2, -1, 1'b0, 1'b0, 2'b11, 4'h0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'h0,  2, -1, 1'b0, 1'b0, 2'b11, 4'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 20,  6, 1'b0, 1'b1, 2'b01, 4'h0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 12, -1, 1'b0, 1'b0, 2'b11, 4'h0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'hB,  6, -1, 1'b0, 1'b0, 2'b11, 4'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 4'hB, 12,  6, 1'b1, 1'b0, 2'b11, 4'hB};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'h5, 12, -1, 1'b0, 1'b0, 2'b11, 4'hB};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 4'h5, 20, -1, 1'b0, 1'b0, 2'b11, 4'hB};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'h5, 12, -1, 1'b0, 1'b0, 2'b11, 4'hB};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 4'h6, 20,  6, 1'b1, 1'b0, 2'b11, 4'h6};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 4'h6, 12, -1, 1'b0, 1'b0, 2'b11, 4'h6};

    reset = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0;
    sw_dir = 1'b0; sw_auto = 1'b0; sw_data = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(outs()), 32'({1'b0, 1'b0, 2'b11, 4'h0}));
    reset = 1'b1;

    for (int i = 0; i < 16; i++) apply(tbl[i], i);

    // Auto-run: ticks at prescaler wrap, direction follows sw_dir, stop clears prescaler.
    for (int k = 0; k < 96; k++) begin
      logic       pulse;
      logic [7:0] exp;
      if (k == 0) begin sw_dir = 1'b1; sw_auto = 1'b1; end
      if (k == 44) sw_dir = 1'b0;
      if (k == 80) sw_auto = 1'b0;
      @(posedge clk);
      @(negedge clk);
      pulse = (k >= 9) && (((k - 9) % 8) == 0) && (k <= 81);
      if (pulse) exp = {1'b0, 1'b1, (k < 44) ? 2'b01 : 2'b00, held_data};
      else       exp = {1'b0, 1'b0, 2'b11, held_data};
      check($sformatf("auto_cyc%0d", k), 32'(outs()), 32'(exp));
      if (k >= 84) check($sformatf("auto_pre_cyc%0d", k), 32'(dut.pre_reg), 32'd0);
    end
    $display("auto: 96 cycles, dir down then up, stopped at cycle 80");

    // Reset with btn_up mid-debounce; the still-held button must not fire afterwards.
    btn_up = 1'b1;
    sw_data = 4'h0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_mid_press", 32'(outs()), 32'({1'b0, 1'b0, 2'b11, 4'h0}));
    held_data = 4'h0;
    $display("reset asserted mid-press: data_in=%h c=%b", data_in, c);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    apply('{1'b1, 1'b0, 1'b0, 4'h0, 20, -1, 1'b0, 1'b0, 2'b11, 4'h0}, 100);
    apply('{1'b0, 1'b0, 1'b0, 4'h0, 20, -1, 1'b0, 1'b0, 2'b11, 4'h0}, 101);
    apply('{1'b1, 1'b0, 1'b0, 4'h0, 20,  6, 1'b0, 1'b1, 2'b00, 4'h0}, 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
